button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive synchronized samples required to accept a level change (legal range 2..255).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, meaning the width of the stability counter (must satisfy 2^CNT_WIDTH > STABLE_CYCLES).
REQ-003 The module SHALL have port in_clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port in_reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_button, input, 1 bit: the raw, asynchronous, bouncing board push-button level (1 = pressed).
REQ-006 The module SHALL have port out_level, output, 1 bit: the debounced button level.
REQ-007 The module SHALL have port out_press, output, 1 bit: a one-cycle pulse on each accepted 0->1 transition.
REQ-008 The module SHALL have port out_release, output, 1 bit: a one-cycle pulse on each accepted 1->0 transition.
REQ-009 The module SHALL have port out_press_count, output, 8 bits: the count of accepted presses since reset.

Function
REQ-010 The module SHALL pass in_button through a two-flop synchronizer; the second-flop output (sync) is the only value the FSM examines.
REQ-011 The FSM SHALL have four states: LOW, WAIT_HIGH, HIGH and WAIT_LOW.
REQ-012 In LOW with sync=1, the FSM SHALL go to WAIT_HIGH and clear the counter to 0; with sync=0 it SHALL stay in LOW.
REQ-013 In WAIT_HIGH with sync=0, the FSM SHALL return to LOW with no output pulse (glitch rejected).
REQ-014 In WAIT_HIGH with sync=1 and counter < STABLE_CYCLES-1, the counter SHALL increment.
REQ-015 In WAIT_HIGH with sync=1 and counter == STABLE_CYCLES-1, the FSM SHALL go to HIGH and assert out_press for exactly that next cycle.
REQ-016 HIGH and WAIT_LOW SHALL behave as the mirror image of LOW and WAIT_HIGH with sync inverted; the accepting transition to LOW asserts out_release for one cycle.
REQ-017 out_level SHALL be 1 exactly when the state is HIGH or WAIT_LOW, and SHALL be registered (no combinational path from in_button).
REQ-018 Latency: with in_button clean and held, counting the first rising edge that samples the new value as edge 1, out_level SHALL change on edge STABLE_CYCLES+3 (edge 19 at the default), coincident with the press or release pulse.
REQ-019 Any reversal of sync before acceptance SHALL restart qualification from the stable state, with the counter cleared on the next entry to a WAIT state.
REQ-020 out_press_count SHALL increment by 1 on the same edge that raises out_press, and SHALL wrap from 255 to 0 without saturating.
REQ-021 out_press and out_release SHALL never be asserted in the same cycle, and neither SHALL be asserted for two consecutive cycles.

Reset
REQ-022 While in_reset_n=0, the module SHALL immediately clear both synchronizer flops, the counter, the state (to LOW), out_level, out_press, out_release and out_press_count to 0, independent of in_clock.
REQ-023 Reset asserted mid-qualification or mid-pulse SHALL abort it with no further pulse after release.
REQ-024 If in_button is held at 1 through reset release, the module SHALL report it as a normal press after the REQ-018 latency.

Verification
REQ-025 Clean press: in_button 0->1, held for 40 cycles -> out_level rises on edge 19; out_press is high for 1 cycle; out_press_count = 1.
REQ-026 Bounce rejection: in_button toggles with high periods of 5, 3 and 10 cycles separated by 1-cycle lows -> no out_press and out_level remains 0; a following steady high of 20 cycles -> exactly one press.
REQ-027 Release: from HIGH, in_button 1->0, held -> out_release pulses once on edge 19 and out_level falls; out_press_count is unchanged.
REQ-028 Wrap: 256 clean presses (STABLE_CYCLES=2 permitted) -> out_press_count reads 255 after the 255th press and 0 after the 256th.
REQ-029 Mid-operation reset: assert in_reset_n=0 asynchronously at counter=7 in WAIT_HIGH -> all outputs 0 immediately; release with in_button=1 -> press reported 19 edges after the first post-reset edge.
REQ-030 Continuous assertion check: out_press and out_release never high together and never high for two consecutive cycles over a randomized bounce run of at least 10k cycles.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state qualification FSM.
// Emits a registered level, one-cycle press/release pulses and a wrapping press counter.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_button,
  output logic       out_level,
  output logic       out_press,
  output logic       out_release,
  output logic [7:0] out_press_count
);

  typedef enum logic [1:0] {
    StLow      = 2'd0,
    StWaitHigh = 2'd1,
    StHigh     = 2'd2,
    StWaitLow  = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic [7:0]           press_count_q, press_count_d;
  logic                 sync;

  assign sync = sync_q[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    press_d       = 1'b0;
    release_d     = 1'b0;
    press_count_d = press_count_q;
    unique case (state_q)
      StLow: begin
        if (sync) begin
          state_d = StWaitHigh;
          cnt_d   = '0;
        end
      end
      StWaitHigh: begin
        if (!sync) begin
          state_d = StLow;
        end else if (cnt_q == CntLast) begin
          state_d       = StHigh;
          level_d       = 1'b1;
          press_d       = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StHigh: begin
        if (!sync) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (sync) begin
          state_d = StHigh;
        end else if (cnt_q == CntLast) begin
          state_d   = StLow;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = StLow;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sync_q        <= 2'b00;
      state_q       <= StLow;
      cnt_q         <= '0;
      level_q       <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      sync_q        <= {sync_q[0], in_button};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      press_q       <= press_d;
      release_q     <= release_d;
      press_count_q <= press_count_d;
    end
  end

  assign out_level       = level_q;
  assign out_press       = press_q;
  assign out_release     = release_q;
  assign out_press_count = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected pulses, a monitor checks them.
module tb_button_debounce;

  localparam int Lat = 19;

  typedef struct {
    bit         is_press;
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       level;
  logic       press;
  logic       release_p;
  logic [7:0] press_count;

  int         cyc;
  int         checks;
  int         failures;
  exp_t       q[$];
  logic [7:0] exp_cnt;

  button_debounce dut (
    .in_clock       (clk),
    .in_reset_n     (rst_n),
    .in_button      (btn),
    .out_level      (level),
    .out_press      (press),
    .out_release    (release_p),
    .out_press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pulse invariants every cycle, and each pulse against the scoreboard head.
  initial begin
    logic prev_p, prev_r;
    exp_t e;
    prev_p = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_p = 1'b0;
        prev_r = 1'b0;
      end else begin
        checks++;
        if ((press && release_p) || (press && prev_p) || (release_p && prev_r)) begin
          failures++;
          $display("FAIL pulse_invariant: press=%0b release=%0b prev_press=%0b prev_release=%0b",
                   press, release_p, prev_p, prev_r);
        end
        if (press || release_p) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: press=%0b release=%0b at cycle %0d expected none",
                     press, release_p, cyc);
          end else begin
            e = q.pop_front();
            chk("pulse_kind_is_press", int'(press), int'(e.is_press));
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_level", int'(level), e.is_press ? 1 : 0);
            chk("pulse_press_count", int'(press_count), int'(e.cnt));
          end
        end
        prev_p = press;
        prev_r = release_p;
      end
    end
  end

  // Caller sits just after a negedge; the next posedge is edge 1 for the new level.
  task automatic drive(input logic v, input int hold, input bit expect_pulse);
    exp_t e;
    btn = v;
    if (expect_pulse) begin
      e.is_press = v;
      if (v) exp_cnt = exp_cnt + 8'd1;
      e.cyc = cyc + Lat;
      e.cnt = exp_cnt;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL missing_pulse: %0d expected pulses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_press"}, int'(press), 0);
    chk({tag, "_release"}, int'(release_p), 0);
    chk({tag, "_count"}, int'(press_count), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit   stable;
    int   start;
    int   runs;
    checks   = 0;
    failures = 0;
    exp_cnt  = 8'd0;
    rst_n    = 1'b0;
    btn      = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("init");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press held 40 cycles, then release.
    drive(1'b1, 40, 1'b1);
    wait_drain(10);
    chk("clean_press_level", int'(level), 1);
    chk("clean_press_count", int'(press_count), 1);
    drive(1'b0, 40, 1'b1);
    wait_drain(10);
    chk("release_level", int'(level), 0);
    chk("release_count_unchanged", int'(press_count), 1);

    // Bounce: highs of 5, 3, 10 separated by single lows must be rejected.
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 1, 1'b0);
    drive(1'b1, 3, 1'b0);
    drive(1'b0, 1, 1'b0);
    drive(1'b1, 10, 1'b0);
    drive(1'b0, 1, 1'b0);
    chk("bounce_level_low", int'(level), 0);
    chk("bounce_count", int'(press_count), 1);
    drive(1'b1, 20, 1'b1);
    wait_drain(10);
    chk("bounce_then_steady_count", int'(press_count), 2);
    drive(1'b0, 25, 1'b1);
    wait_drain(10);

    // Asynchronous reset in WAIT_HIGH with counter at 7, button kept high through release.
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    @(negedge clk);
    exp_cnt = 8'd0;
    rst_n = 1'b1;
    drive(1'b1, 25, 1'b1);
    wait_drain(10);
    chk("post_reset_press_count", int'(press_count), 1);
    drive(1'b0, 25, 1'b1);
    wait_drain(10);

    // Wrap of the press counter over 256 presses.
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      drive(1'b1, 20, 1'b1);
      wait_drain(10);
      if (i == 255) chk("wrap_count_255", int'(press_count), 255);
      if (i == 256) chk("wrap_count_256", int'(press_count), 0);
      drive(1'b0, 20, 1'b1);
      wait_drain(10);
    end

    // Random bounce bursts (runs too short to qualify) followed by steady holds.
    stable = 1'b0;
    start  = cyc;
    while (cyc - start < 10500) begin
      runs = $urandom_range(1, 4);
      for (int r = 0; r < runs; r++) begin
        drive(~stable, $urandom_range(1, 14), 1'b0);
        drive(stable, $urandom_range(1, 14), 1'b0);
      end
      drive(~stable, $urandom_range(22, 40), 1'b1);
      stable = ~stable;
    end
    wait_drain(30);
    chk("random_final_level", int'(level), int'(stable));
    chk("random_final_count", int'(press_count), int'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
